// File: rtl/spram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spram_access_ctrl
// Purpose  : Request sequencer in front of a single-port RAM wrapper. Turns a
//            valid/ready stream of reads and writes into one-cycle RAM
//            accesses, follows the RAM read latency with a tag pipeline and
//            returns read data in order through a first-word-fall-through
//            response FIFO. Read credits guarantee that every read issued
//            has a free FIFO slot when its data arrives.
// Ports    : clk, reset (synchronous, active-low)
//            req_*      - request stream (valid/ready, we, addr, wdata, byteen)
//            rsp_*      - read response stream (valid/ready, rdata)
//            ram_*      - registered RAM pin drive, ram_rdata from the RAM,
//                         ram_reset = ~reset (combinational)
//            init_done  - high once requests can be accepted
// Options  : SPRAM_CTRL_INIT_EN - when defined, clears the whole RAM (one
//            write per cycle, data 0, all byte enables) after every reset
//            before accepting requests.
// Revision : 1.0 - initial release
// ============================================================================
module spram_access_ctrl #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 16,
    parameter int BYTEEN_WIDTH = 2,
    parameter int OUTPUT_REG   = 0,
    parameter int RSP_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    // request stream
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [BYTEEN_WIDTH-1:0] req_byteen,
    // response stream
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    // RAM pins
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic                    ram_we,
    output logic                    ram_wclke,
    output logic [BYTEEN_WIDTH-1:0] ram_byteen,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic                    ram_re,
    output logic                    ram_addren,
    output logic                    ram_reset,
    input  logic [DATA_WIDTH-1:0]   ram_rdata,
    // status
    output logic                    init_done
);

    // RAM read latency in cycles after the access cycle
    localparam int c_lat   = 1 + OUTPUT_REG;
    localparam int c_ptr_w = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    // tag pipeline holds at most 3 reads, so two extra bits cover the sum
    localparam int c_out_w = c_cnt_w + 2;
    localparam logic [c_out_w-1:0] c_depth = c_out_w'(RSP_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_INIT = 1'b1
    } state_t;

`ifdef SPRAM_CTRL_INIT_EN
    localparam state_t c_reset_state = ST_INIT;
    localparam logic [ADDR_WIDTH-1:0] c_addr_max = '1;
`else
    localparam state_t c_reset_state = ST_RUN;
`endif

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_init_done;
`ifdef SPRAM_CTRL_INIT_EN
    logic [ADDR_WIDTH-1:0]   r_init_addr;
    logic                    w_init_issue;
`endif

    logic                    w_req_accept;
    logic                    w_rd_accept;
    logic                    w_rd_credit_ok;
    logic [c_lat:0]          r_tag;
    logic [c_out_w-1:0]      w_tag_cnt;
    logic [c_out_w-1:0]      w_outstanding;

    logic [DATA_WIDTH-1:0]   r_mem [RSP_DEPTH];
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_cnt_w-1:0]      r_count;
    logic                    w_push;
    logic                    w_pop;

    assign ram_reset    = ~reset;
    assign init_done    = r_init_done;
    assign w_req_accept = req_valid & req_ready;
    assign w_rd_accept  = w_req_accept & ~req_we;

    // ------------------------------------------------------------------------
    // Credits: every read between acceptance and FIFO pop owns one slot.
    // Only registered state is used, so a pop frees its credit one cycle late.
    // ------------------------------------------------------------------------
    always_comb begin
        w_tag_cnt = '0;
        for (int i = 0; i <= c_lat; i++) begin
            w_tag_cnt = w_tag_cnt + c_out_w'(r_tag[i]);
        end
        w_outstanding  = w_tag_cnt + {2'b00, r_count};
        w_rd_credit_ok = (w_outstanding < c_depth);
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_reset_state;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_init_done <= (w_state_next == ST_RUN);
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
`ifdef SPRAM_CTRL_INIT_EN
        w_init_issue = 1'b0;
`endif
        case (r_state)
`ifdef SPRAM_CTRL_INIT_EN
            ST_INIT: begin
                w_init_issue = 1'b1;
                if (r_init_addr == c_addr_max) begin
                    w_state_next = ST_RUN;
                end
            end
`endif
            ST_RUN: begin
                // r_init_done masks the first cycle after reset release
                req_ready = r_init_done & (req_we | w_rd_credit_ok);
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

`ifdef SPRAM_CTRL_INIT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_init_addr <= '0;
        end else if (w_init_issue) begin
            r_init_addr <= r_init_addr + 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Issue stage: RAM pins are driven for exactly one cycle per access.
    // Address and write data hold their last value between accesses.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_byteen <= '0;
            ram_we     <= 1'b0;
            ram_wclke  <= 1'b0;
            ram_re     <= 1'b0;
            ram_addren <= 1'b0;
        end else begin
            ram_byteen <= '0;
            ram_we     <= 1'b0;
            ram_wclke  <= 1'b0;
            ram_re     <= 1'b0;
            ram_addren <= 1'b0;
`ifdef SPRAM_CTRL_INIT_EN
            if (w_init_issue) begin
                ram_addr   <= r_init_addr;
                ram_wdata  <= '0;
                ram_byteen <= '1;
                ram_we     <= 1'b1;
                ram_wclke  <= 1'b1;
                ram_addren <= 1'b1;
            end else
`endif
            if (w_req_accept) begin
                ram_addr   <= req_addr;
                ram_addren <= 1'b1;
                if (req_we) begin
                    ram_we     <= 1'b1;
                    ram_wclke  <= 1'b1;
                    ram_byteen <= req_byteen;
                    ram_wdata  <= req_wdata;
                end else begin
                    ram_re     <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read tag pipeline: bit 0 marks the RAM access cycle, bit c_lat marks
    // the cycle in which ram_rdata carries that read's data.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tag <= '0;
        end else begin
            r_tag <= {r_tag[c_lat-1:0], w_rd_accept};
        end
    end

    // ------------------------------------------------------------------------
    // Response FIFO (first-word-fall-through). Credits keep it from overflowing.
    // ------------------------------------------------------------------------
    assign w_push    = r_tag[c_lat];
    assign w_pop     = rsp_valid & rsp_ready;
    assign rsp_valid = (r_count != '0);
    assign rsp_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spram_access_ctrl
// Purpose  : Self-checking bench for spram_access_ctrl. A behavioural RAM
//            model answers the RAM pins; a reference memory plus a queue of
//            expected responses predicts req_ready, rsp_valid timing, read
//            data order/value and the RAM pin activity each cycle.
//            SPRAM_CTRL_INIT_EN selects the clear-on-reset expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spram_access_ctrl;
    parameter int OUTPUT_REG = 0;

    localparam int AW     = 10;
    localparam int DW     = 16;
    localparam int BW     = 2;
    localparam int DEPTH  = 4;
    localparam int NWORDS = 1 << AW;
    // negedge samples from the accept decision to the first rsp_valid sample
    localparam int RSP_LAT = 3 + OUTPUT_REG;

    logic          clk;
    logic          reset;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_byteen;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we, ram_wclke, ram_re, ram_addren, ram_reset;
    logic [BW-1:0] ram_byteen;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          init_done;

    spram_access_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BYTEEN_WIDTH(BW),
        .OUTPUT_REG  (OUTPUT_REG),
        .RSP_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_byteen(req_byteen),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wclke (ram_wclke),
        .ram_byteen(ram_byteen),
        .ram_wdata (ram_wdata),
        .ram_re    (ram_re),
        .ram_addren(ram_addren),
        .ram_reset (ram_reset),
        .ram_rdata (ram_rdata),
        .init_done (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural single-port RAM ----------------
    logic [DW-1:0] ram_mem [NWORDS];
    logic [DW-1:0] ram_q1, ram_q2;

    always @(posedge clk) begin
        if (ram_addren && ram_we) begin
            for (int b = 0; b < BW; b++) begin
                if (ram_byteen[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        if (ram_addren && ram_re) ram_q1 <= ram_mem[ram_addr];
        ram_q2 <= ram_q1;
    end
    assign ram_rdata = (OUTPUT_REG != 0) ? ram_q2 : ram_q1;

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [NWORDS];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            armed = 0;
    bit            running = 0;
    bit            pin_act = 0;
    bit            pin_we = 0;
    logic [AW-1:0] pin_addr;
    logic [DW-1:0] pin_wdata;
    logic [BW-1:0] pin_be;
`ifdef SPRAM_CTRL_INIT_EN
    bit            init_active = 0;
    int            init_idx = 0;
`endif

    initial begin
        for (int a = 0; a < NWORDS; a++) begin
            ram_mem[a] = DW'(a * 97 + 16'h1357);
            ref_mem[a] = DW'(a * 97 + 16'h1357);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare outputs with the model, then advance the model over
    // the coming rising edge using the (stable) inputs of this cycle.
    always @(negedge clk) begin : monitor
        bit exp_valid;
        bit exp_ready;
        cyc++;
        exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        exp_ready = running && (req_we || exp_q.size() < DEPTH);
        if (armed) begin
            check("init_done", init_done, running);
            check("req_ready", req_ready, exp_ready);
            check("rsp_valid", rsp_valid, exp_valid);
            if (exp_valid && rsp_ready) check("rsp_rdata", rsp_rdata, exp_q[0].data);
            check("ram_addren", ram_addren, pin_act);
            check("ram_we", ram_we, pin_act && pin_we);
            check("ram_wclke", ram_wclke, pin_act && pin_we);
            check("ram_re", ram_re, pin_act && !pin_we);
            check("ram_reset", ram_reset, !reset);
            if (pin_act) begin
                check("ram_addr", ram_addr, pin_addr);
                if (pin_we) begin
                    check("ram_wdata", ram_wdata, pin_wdata);
                    check("ram_byteen", ram_byteen, pin_be);
                end else begin
                    check("ram_byteen_rd", ram_byteen, 0);
                end
            end
            assert (exp_q.size() <= DEPTH) else begin
                errors++;
                $display("FAIL fifo_overflow at cycle %0d: outstanding %0d, limit %0d", cyc, exp_q.size(), DEPTH);
            end
        end

        if (reset === 1'b0) begin
            armed   = 1;
            running = 0;
            pin_act = 0;
            exp_q.delete();
`ifdef SPRAM_CTRL_INIT_EN
            init_active = 1;
            init_idx    = 0;
`endif
        end else if (armed) begin
            pin_act = 0;
            if (exp_valid && rsp_ready) void'(exp_q.pop_front());
`ifdef SPRAM_CTRL_INIT_EN
            if (init_active) begin
                pin_act   = 1;
                pin_we    = 1;
                pin_addr  = AW'(init_idx);
                pin_wdata = '0;
                pin_be    = '1;
                ref_mem[init_idx] = '0;
                if (init_idx == NWORDS - 1) begin
                    init_active = 0;
                    running     = 1;
                end else begin
                    init_idx++;
                end
            end else
`endif
            if (!running) begin
                running = 1;
            end else if (req_valid && exp_ready) begin
                pin_act  = 1;
                pin_we   = req_we;
                pin_addr = req_addr;
                if (req_we) begin
                    pin_wdata = req_wdata;
                    pin_be    = req_byteen;
                    for (int b = 0; b < BW; b++) begin
                        if (req_byteen[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                    end
                end else begin
                    exp_q.push_back('{ref_mem[req_addr], cyc + RSP_LAT});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (init_done !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 3000) begin
                checks++;
                errors++;
                $display("FAIL init_timeout: init_done %b after %0d cycles, expected 1", init_done, n);
                break;
            end
        end
    endtask

    task automatic do_req(input bit we, input int addr, input int data, input int be);
        int waited = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = AW'(addr);
        req_wdata  = DW'(data);
        req_byteen = BW'(be);
        forever begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL req_timeout: we=%0d addr=%h not accepted after %0d cycles, expected accept", we, addr, waited);
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin : driver
        int blocked;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_byteen = '0;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        wait_ready();

        // Untouched contents (or cleared contents when the clear walk is on)
        do_req(0, 'h007, 0, 0);
        idle(6);

        // Write then read back; latency is checked on every cycle by the monitor
        do_req(1, 'h010, 'hA5A5, 'b11);
        do_req(0, 'h010, 0, 0);
        idle(6);

        // Partial byte write
        do_req(1, 'h030, 'h1234, 'b11);
        do_req(1, 'h030, 'h00FF, 'b01);
        do_req(0, 'h030, 0, 0);
        idle(6);

        // Distinct data at 0..7, then backpressure with a full credit pool
        for (int i = 0; i < 8; i++) do_req(1, i, 'h0100 + i * 'h0111, 'b11);
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_req(0, i, 0, 0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = AW'(4);
        blocked   = 0;
        repeat (8) begin
            @(negedge clk);
            if (req_ready === 1'b1) blocked++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("read_accepts_when_full", blocked, 0);
        do_req(1, 'h020, 'hBEEF, 'b11);
        rsp_ready = 1'b1;
        for (int i = 4; i < 8; i++) do_req(0, i, 0, 0);
        idle(10);

        // Reset with one response queued and two reads in flight
        rsp_ready = 1'b0;
        do_req(0, 'h010, 0, 0);
        idle(4);
        do_req(0, 'h011, 0, 0);
        do_req(0, 'h012, 0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        rsp_ready = 1'b1;
        idle(8);
        wait_ready();
        idle(4);

        // Randomised mixed traffic over a small address window
        for (int i = 0; i < 600; i++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_we     = 1'($urandom_range(0, 1));
            req_addr   = AW'($urandom_range(0, 15));
            req_wdata  = DW'($urandom);
            req_byteen = BW'($urandom);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("drain_remaining", exp_q.size(), 0);
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spram_access_ctrl.md
Name: spram_access_ctrl

Overview:
Request sequencer that sits directly upstream of the single-port RAM wrapper and drives its addr/we/re/byteen/wdata/addren pins. It converts a valid/ready request stream (reads and writes) into single-cycle RAM accesses. It tracks the RAM read latency (1 or 2 cycles, depending on the RAM output register) and returns read data in order through a response FIFO with backpressure. Credit-based flow control ensures no read data is ever lost.

Parameters:
ADDR_WIDTH, 10, RAM address width
DATA_WIDTH, 16, RAM data width
BYTEEN_WIDTH, 2, byte-enable width; DATA_WIDTH must equal 8*BYTEEN_WIDTH
OUTPUT_REG, 0, must match the RAM OUTPUT_REG; RAM read latency LAT = 1+OUTPUT_REG
RSP_DEPTH, 4, response FIFO depth; power of 2, >= 2

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
req_byteen  in  BYTEEN_WIDTH  write byte enables, active high
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer ready
rsp_rdata  out  DATA_WIDTH  read data, in request order
ram_addr  out  ADDR_WIDTH  to RAM addr
ram_we  out  1  to RAM we, active high
ram_wclke  out  1  to RAM wclke, equal to ram_we
ram_byteen  out  BYTEEN_WIDTH  to RAM byteen
ram_wdata  out  DATA_WIDTH  to RAM wdata
ram_re  out  1  to RAM re, active high
ram_addren  out  1  to RAM addren; high on any issued access
ram_reset  out  1  to RAM reset, active high; equals ~reset
ram_rdata  in  DATA_WIDTH  from RAM rdata
init_done  out  1  high once the block accepts requests

Behaviour:
- Reset (reset=0 at a clock edge): the following are 0: req_ready, rsp_valid, ram_we, ram_wclke, ram_re, ram_addren, init_done. FIFO is emptied, read pipeline is cleared, state goes to INIT (macro on) or RUN (macro off). Reset during an operation discards all in-flight reads and queued responses.
- FSM states:
  - INIT: present only with the macro.
  - RUN: normal operation. Without the macro, state is RUN on the first edge after reset release; init_done=1 from then on.
- Issue stage: all ram_* outputs except ram_reset are registered.
  - An accept at edge k drives the RAM pins during cycle k+1 for exactly one cycle.
  - On a cycle with no accept, ram_we, ram_wclke, ram_re and ram_addren are all 0; ram_addr and ram_wdata hold their last values.
- Write: ram_we=ram_wclke=ram_addren=1, ram_byteen=req_byteen, ram_re=0. No response is generated.
- Read: ram_re=ram_addren=1, ram_we=0, ram_byteen=0.
  - A tag shift register of length 1+LAT marks which cycles carry valid RAM data.
  - ram_rdata is pushed into the FIFO at edge k+1+LAT.
  - rsp_valid rises in the cycle after that push. Accept-to-rsp_valid = 2+OUTPUT_REG cycles when the FIFO is empty.
- Credits: outstanding = reads in issue/tag pipeline + FIFO occupancy, computed from registered state.
  - Read ready = (state==RUN) && outstanding < RSP_DEPTH.
  - Write ready = (state==RUN).
  - req_ready follows req_we combinationally.
  - A FIFO pop in the same cycle does not free a credit until the next cycle.
- FIFO: first-word-fall-through; pop on rsp_valid & rsp_ready. Push and pop in the same cycle on a non-empty FIFO leave occupancy unchanged. Overflow is impossible by construction; a bench assertion checks it.
- Ordering: strictly in-order. A read after a write to the same address returns the new data, because accesses are serialized one per cycle.
- Pointers wrap modulo RSP_DEPTH.

Optional Feature:
SPRAM_CTRL_INIT_EN:
- Defined: after reset release the FSM stays in INIT and walks addresses 0..2^ADDR_WIDTH-1, one write per cycle, with wdata=0 and byteen all-ones. req_ready=0 throughout. After the last write issues, state goes to RUN and init_done=1. Total time is 2^ADDR_WIDTH cycles. Reset during INIT restarts the walk at address 0.
- Undefined: no INIT state; RAM contents are left untouched.

Test Plan:
- Write 0xA5A5 to addr 0x010 (byteen 2'b11), then read 0x010, OUTPUT_REG=0 -> rsp_rdata=0xA5A5 two cycles after the read accept.
- Same sequence with OUTPUT_REG=1 -> rsp_valid three cycles after the read accept.
- rsp_ready held 0, back-to-back reads to addr 0..7, RSP_DEPTH=4 -> exactly 4 reads accepted and req_ready low for reads. Writes are still accepted. After releasing rsp_ready, data returns in order 0..7.
- Byte write with byteen=2'b01 and data 0x00FF over 0x1234 -> read returns 0x12FF.
- reset asserted with 2 reads in flight and 1 queued -> rsp_valid=0 next cycle. No stale response appears after reset release.
- With SPRAM_CTRL_INIT_EN and ADDR_WIDTH=4 -> 16 consecutive ram_we pulses at addr 0..15, then init_done=1. A read of 0x7 returns 0.
